// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: steps each PWM channel's pulse width toward a software target,
// one LSB per prescaler tick, and forwards the resulting writes to the PWM bank.
module pwm_fade_ctrl #(
  parameter int unsigned NumCh    = 12,
  parameter int unsigned CtrSize  = 8,
  parameter int unsigned BusWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                device_req_i,
  input  logic [BusWidth-1:0] device_addr_i,
  input  logic                device_we_i,
  input  logic [3:0]          device_be_i,
  input  logic [BusWidth-1:0] device_wdata_i,
  output logic                device_rvalid_o,
  output logic [BusWidth-1:0] device_rdata_o,
  output logic                pwm_req_o,
  output logic [BusWidth-1:0] pwm_addr_o,
  output logic                pwm_we_o,
  output logic [3:0]          pwm_be_o,
  output logic [BusWidth-1:0] pwm_wdata_o,
  input  logic                pwm_gnt_i
);

  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned PerW = 16;
  localparam logic [9:0] AddrCtrl   = 10'h100;
  localparam logic [9:0] AddrPeriod = 10'h104;
  localparam logic [9:0] AddrMaxctr = 10'h108;
  localparam logic [9:0] AddrStatus = 10'h10C;

  typedef enum logic [1:0] {IDLE, INIT, SCAN, WRITE} state_e;

  state_e               state_q, state_d;
  logic [ChW-1:0]       ch_q, ch_d;
  logic [CtrSize-1:0]   target_q  [NumCh];
  logic [CtrSize-1:0]   current_q [NumCh];
  logic                 en_q, init_done_q, tick_pend_q;
  logic [PerW-1:0]      period_q, presc_q;
  logic [CtrSize-1:0]   maxctr_q;

  logic [9:0]           addr;
  logic                 dev_wr, is_ch, en_clr, tick, last_ch;
  logic [ChW-1:0]       idx;
  logic [BusWidth-1:0]  rdata_c;
  logic                 init_set, pend_clr, cur_upd;
  logic [CtrSize-1:0]   cur_new;
  logic                 req_d;
  logic [BusWidth-1:0]  addr_d, wdata_d;
  logic                 unused_bits;

  assign addr    = device_addr_i[9:0];
  assign dev_wr  = device_req_i & device_we_i;
  assign is_ch   = (addr[9:8] == 2'b00) && (32'(addr[7:3]) < NumCh);
  assign idx     = ChW'(addr[7:3]);
  assign en_clr  = dev_wr && (addr == AddrCtrl) && !device_wdata_i[0];
  assign last_ch = (ch_q == ChW'(NumCh - 1));
  assign tick    = en_q && init_done_q &&
                   ((period_q <= PerW'(1)) || (presc_q >= period_q - PerW'(1)));

  assign pwm_we_o    = pwm_req_o;
  assign pwm_be_o    = 4'hF;
  assign unused_bits = ^{device_be_i, device_addr_i[BusWidth-1:10], device_wdata_i[BusWidth-1:PerW]};

  // Register read mux, sampled into rdata on the request cycle
  always_comb begin
    rdata_c = '0;
    if (is_ch) begin
      rdata_c = BusWidth'(addr[2] ? current_q[idx] : target_q[idx]);
    end else begin
      case (addr)
        AddrCtrl:   rdata_c = BusWidth'(en_q);
        AddrPeriod: rdata_c = BusWidth'(period_q);
        AddrMaxctr: rdata_c = BusWidth'(maxctr_q);
        AddrStatus: rdata_c = BusWidth'({init_done_q, state_q != IDLE});
        default:    rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) device_rdata_o <= rdata_c;
    end
  end

  // Software-visible registers and the live pulse widths
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        target_q[i]  <= '0;
        current_q[i] <= '0;
      end
      en_q     <= 1'b0;
      period_q <= '0;
      maxctr_q <= '0;
    end else begin
      if (dev_wr) begin
        if (is_ch && !addr[2]) target_q[idx] <= device_wdata_i[CtrSize-1:0];
        case (addr)
          AddrCtrl:   en_q     <= device_wdata_i[0];
          AddrPeriod: period_q <= device_wdata_i[PerW-1:0];
          AddrMaxctr: maxctr_q <= device_wdata_i[CtrSize-1:0];
          default: ;
        endcase
      end
      if (cur_upd) current_q[ch_q] <= cur_new;
    end
  end

  // Prescaler, coalescing tick flag and init status; disabling clears all three
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      init_done_q <= 1'b0;
    end else if (en_clr) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      if (!(en_q && init_done_q) || tick) presc_q <= '0;
      else                                presc_q <= presc_q + PerW'(1);
      if (tick)          tick_pend_q <= 1'b1;
      else if (pend_clr) tick_pend_q <= 1'b0;
      if (init_set) init_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Next state, channel pointer and the request the next state presents
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    init_set = 1'b0;
    pend_clr = 1'b0;
    cur_upd  = 1'b0;
    cur_new  = current_q[ch_q];
    req_d    = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (en_q && !init_done_q) begin
          state_d = INIT;
          ch_d    = '0;
        end else if (en_q && tick_pend_q) begin
          pend_clr = 1'b1;
          state_d  = SCAN;
          ch_d     = '0;
        end
      end
      INIT: begin
        if (pwm_gnt_i) begin
          if (!en_q) begin
            state_d = IDLE;
          end else if (last_ch) begin
            init_set = 1'b1;
            state_d  = IDLE;
          end else begin
            ch_d = ch_q + ChW'(1);
          end
        end
      end
      SCAN: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (current_q[ch_q] != target_q[ch_q]) begin
          cur_upd = 1'b1;
          cur_new = (current_q[ch_q] < target_q[ch_q]) ? current_q[ch_q] + CtrSize'(1)
                                                       : current_q[ch_q] - CtrSize'(1);
          state_d = WRITE;
        end else if (last_ch) begin
          state_d = IDLE;
        end else begin
          ch_d = ch_q + ChW'(1);
        end
      end
      WRITE: begin
        if (pwm_gnt_i) begin
          if (!en_q || last_ch) begin
            state_d = IDLE;
          end else begin
            state_d = SCAN;
            ch_d    = ch_q + ChW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == INIT) begin
      req_d   = 1'b1;
      addr_d  = (BusWidth'(ch_d) << 3) + BusWidth'(4);
      wdata_d = BusWidth'(maxctr_q);
    end else if (state_d == WRITE) begin
      req_d   = 1'b1;
      addr_d  = BusWidth'(ch_d) << 3;
      wdata_d = BusWidth'(cur_new);
    end
  end

  // Request fields are frozen while a request waits for grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_req_o   <= 1'b0;
      pwm_addr_o  <= '0;
      pwm_wdata_o <= '0;
    end else if (!(pwm_req_o && !pwm_gnt_i)) begin
      pwm_req_o   <= req_d;
      pwm_addr_o  <= addr_d;
      pwm_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: expected PWM-bank writes are queued as
// stimulus is issued and matched against each granted request.
module tb_pwm_fade_ctrl;

  localparam int unsigned NumCh = 12;
  localparam logic [9:0] Ctrl   = 10'h100;
  localparam logic [9:0] Period = 10'h104;
  localparam logic [9:0] Maxctr = 10'h108;
  localparam logic [9:0] Status = 10'h10C;

  logic        clk, rst;
  logic        device_req, device_we, device_rvalid;
  logic [31:0] device_addr, device_wdata, device_rdata;
  logic [3:0]  device_be;
  logic        pwm_req, pwm_we, pwm_gnt;
  logic [31:0] pwm_addr, pwm_wdata;
  logic [3:0]  pwm_be;

  pwm_fade_ctrl #(.NumCh(NumCh), .CtrSize(8), .BusWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .device_req_i(device_req), .device_addr_i(device_addr), .device_we_i(device_we),
    .device_be_i(device_be), .device_wdata_i(device_wdata),
    .device_rvalid_o(device_rvalid), .device_rdata_o(device_rdata),
    .pwm_req_o(pwm_req), .pwm_addr_o(pwm_addr), .pwm_we_o(pwm_we),
    .pwm_be_o(pwm_be), .pwm_wdata_o(pwm_wdata), .pwm_gnt_i(pwm_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          extra_cnt = 0;
  int          hs_cyc[$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every granted request is one PWM-bank write; match it against the queue
  always @(negedge clk) begin
    if (pwm_req && pwm_gnt) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        extra_cnt++;
        $display("unexpected pwm write addr=0x%0h data=0x%0h", pwm_addr, pwm_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("pwm_addr", pwm_addr, e[63:32]);
        check("pwm_wdata", pwm_wdata, e[31:0]);
        check("pwm_we", {31'b0, pwm_we}, 32'd1);
      end
    end
  end

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    device_req = 1'b1; device_we = 1'b1; device_addr = {22'b0, a}; device_wdata = d;
    @(posedge clk); #1;
    device_req = 1'b0; device_we = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    device_req = 1'b1; device_we = 1'b0; device_addr = {22'b0, a};
    @(posedge clk); #1;
    device_req = 1'b0;
    check("rvalid", {31'b0, device_rvalid}, 32'd1);
    d = device_rdata;
  endtask

  task automatic push_init(input logic [31:0] d);
    for (int i = 0; i < NumCh; i++) exp_q.push_back({32'(i * 8 + 4), d});
  endtask

  task automatic push_ramp(input logic [31:0] a, input int from, input int to);
    int v = from;
    while (v != to) begin
      v = (v < to) ? v + 1 : v - 1;
      exp_q.push_back({a, 32'(v)});
    end
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    repeat (n) @(posedge clk);
    check(tag, 32'(extra_cnt), 32'd0);
  endtask

  task automatic check_gaps(input string tag, input int first, input int last, input int gap);
    for (int i = first; i <= last && i < hs_cyc.size(); i++)
      check(tag, 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(gap));
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pwm_req) break;
    end
    check("req_seen", {31'b0, pwm_req}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; device_req = 1'b0; device_we = 1'b0; device_addr = '0;
    device_wdata = '0; device_be = 4'hF; pwm_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'b0, pwm_req}, 32'd0);
    check("rst_addr", pwm_addr, 32'd0);
    check("rst_wdata", pwm_wdata, 32'd0);
    check("rst_rvalid", {31'b0, device_rvalid}, 32'd0);
    check("rst_rdata", device_rdata, 32'd0);
    check("pwm_be", {28'b0, pwm_be}, 32'hF);
    rst = 1'b0;

    // Init: twelve max-counter writes in consecutive cycles
    bus_write(Maxctr, 32'hFF);
    bus_write(Period, 32'h100);
    hs_cyc.delete();
    push_init(32'hFF);
    bus_write(Ctrl, 32'h1);
    wait_empty("init_done", 200);
    check("init_count", 32'(hs_cyc.size()), 32'd12);
    check_gaps("init_gap", 1, 11, 1);
    bus_read(Status, rd);
    check("status_init", rd, 32'h2);

    // Ramp channel 3 up to 5 with PERIOD=4
    bus_write(Period, 32'd4);
    hs_cyc.delete();
    push_ramp(32'h18, 0, 5);
    bus_write(10'h18, 32'd5);
    wait_empty("ramp3", 1000);
    check_gaps("ramp3_gap", 1, 4, 14);
    quiet("ramp3_quiet", 60);
    bus_write(10'h1C, 32'h77);
    bus_read(10'h1C, rd);
    check("current3", rd, 32'd5);
    bus_read(10'h18, rd);
    check("target3", rd, 32'd5);
    bus_write(10'h200, 32'hDEAD);
    bus_read(10'h200, rd);
    check("unmapped", rd, 32'd0);

    // Channel 0 up to 3, then back down to 0
    push_ramp(32'h0, 0, 3);
    bus_write(10'h00, 32'd3);
    wait_empty("ramp0_up", 1000);
    hs_cyc.delete();
    push_ramp(32'h0, 3, 0);
    bus_write(10'h00, 32'd0);
    wait_empty("ramp0_down", 1000);
    check_gaps("ramp0_gap", 1, 2, 14);
    quiet("ramp0_quiet", 40);

    // Grant withheld: request fields hold and exactly one transfer completes
    pwm_gnt = 1'b0;
    exp_q.push_back({32'h28, 32'd1});
    bus_write(10'h28, 32'd1);
    wait_req(200);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_req", {31'b0, pwm_req}, 32'd1);
      check("hold_addr", pwm_addr, 32'h28);
      check("hold_wdata", pwm_wdata, 32'd1);
    end
    @(posedge clk); #1;
    pwm_gnt = 1'b1;
    wait_empty("hold_xfer", 50);
    quiet("hold_quiet", 40);

    // Disable while a request is pending; it completes, then silence
    pwm_gnt = 1'b0;
    exp_q.push_back({32'h38, 32'd1});
    bus_write(10'h38, 32'd9);
    wait_req(200);
    bus_write(Ctrl, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    pwm_gnt = 1'b1;
    wait_empty("dis_xfer", 50);
    quiet("dis_quiet", 60);
    bus_read(Status, rd);
    check("status_dis", rd, 32'h0);
    bus_read(10'h3C, rd);
    check("current7", rd, 32'd1);

    // Re-enable: full re-init, then channel 7 resumes its ramp
    hs_cyc.delete();
    push_init(32'hFF);
    push_ramp(32'h38, 1, 9);
    bus_write(Ctrl, 32'h1);
    wait_empty("reinit", 3000);
    check_gaps("reinit_gap", 1, 11, 1);
    quiet("reinit_quiet", 40);

    // PERIOD=0: back-to-back passes, one write per pass
    bus_write(Period, 32'd0);
    hs_cyc.delete();
    push_ramp(32'h08, 0, 2);
    bus_write(10'h08, 32'd2);
    wait_empty("p0_ramp", 500);
    check_gaps("p0_gap", 1, 1, 14);
    quiet("p0_quiet", 60);
    bus_read(10'h0C, rd);
    check("current1", rd, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
